// File: rtl/i2c_reg_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | i2c_reg_arbiter                                                          |
// | Arbitrates one single-port register file between I2C slave writes, a     |
// | req/ack host port, and shadow refreshes of the I2C read data.            |
// | Optional feature macro: I2C_ARB_WP_EN (I2C write protection >= WP_BASE). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_reg_arbiter #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter int                REFRESH_MAX = 16,
  parameter logic [ADDR_W-1:0] WP_BASE     = 8'hF0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_reg_addr,
  input  logic [DATA_W-1:0] i2c_datao,
  input  logic              i2c_busy,
  output logic [DATA_W-1:0] i2c_datai,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              wp_violation
);

  localparam int            c_TW   = $clog2(REFRESH_MAX + 1);
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(REFRESH_MAX);
`ifdef I2C_ARB_WP_EN
  localparam bit c_WP_EN = 1'b1;
`else
  localparam bit c_WP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_I2C_WR  = 3'd1,
    OP_HOST_WR = 3'd2,
    OP_HOST_RD = 3'd3,
    OP_REFRESH = 3'd4
  } op_e;

  op_e               r_last_op;
  op_e               r_cap_op;
  op_e               w_grant;
  logic              r_stale;
  logic              r_ref_dirty;
  logic              r_busy_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [ADDR_W-1:0] r_ref_addr;
  logic [c_TW-1:0]   r_timer;

  logic [ADDR_W-1:0] w_rf_addr;
  logic              w_rf_we;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_wp_hit;
  logic              w_host_inflight;
  logic              w_ref_inflight;
  logic              w_force;
  logic              w_host_ok;
  logic              w_wr_hit;
  logic              w_stale_evt;
  logic              w_ref_clear;

  assign w_wp_hit        = c_WP_EN && i2c_we && (i2c_reg_addr >= WP_BASE);
  assign w_host_inflight = (r_last_op == OP_HOST_WR) || (r_last_op == OP_HOST_RD) ||
                           (r_cap_op == OP_HOST_RD);
  assign w_ref_inflight  = (r_last_op == OP_REFRESH) || (r_cap_op == OP_REFRESH);
  assign w_force         = r_stale && (r_timer >= c_TMAX) && !w_ref_inflight;
  assign w_host_ok       = host_req && !w_host_inflight && !host_ack;

  // Slot grant: exactly one op per cycle, issued on rf_* next cycle
  always_comb begin
    w_grant    = OP_NONE;
    w_rf_addr  = rf_addr;
    w_rf_we    = 1'b0;
    w_rf_wdata = rf_wdata;
    if (i2c_we) begin
      w_grant    = OP_I2C_WR;
      w_rf_addr  = i2c_reg_addr;
      w_rf_wdata = i2c_datao;
      w_rf_we    = !w_wp_hit;
    end else if (w_force) begin
      w_grant   = OP_REFRESH;
      w_rf_addr = i2c_reg_addr;
    end else if (w_host_ok) begin
      w_grant    = host_we ? OP_HOST_WR : OP_HOST_RD;
      w_rf_addr  = host_addr;
      w_rf_we    = host_we;
      w_rf_wdata = host_wdata;
    end else if (r_stale && !w_ref_inflight) begin
      w_grant   = OP_REFRESH;
      w_rf_addr = i2c_reg_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_op <= OP_NONE;
      r_cap_op  <= OP_NONE;
    end else begin
      r_last_op <= w_grant;
      r_cap_op  <= r_last_op;
    end
  end

  // Stale events are detected at grant time so a write granted during a refresh capture still wins
  assign w_wr_hit    = ((w_grant == OP_I2C_WR) && !w_wp_hit) ||
                       ((w_grant == OP_HOST_WR) && (host_addr == i2c_reg_addr));
  assign w_stale_evt = (i2c_reg_addr != r_addr_q) || (i2c_busy && !r_busy_q) || w_wr_hit;
  assign w_ref_clear = (r_cap_op == OP_REFRESH) && !r_ref_dirty && (i2c_reg_addr == r_ref_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_addr     <= '0;
      rf_we       <= 1'b0;
      rf_wdata    <= '0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      i2c_datai   <= '0;
      r_stale     <= 1'b1;
      r_timer     <= '0;
      r_ref_dirty <= 1'b0;
      r_ref_addr  <= '0;
      r_addr_q    <= '0;
      r_busy_q    <= 1'b0;
    end else begin
      rf_addr  <= w_rf_addr;
      rf_we    <= w_rf_we;
      rf_wdata <= w_rf_wdata;
      r_addr_q <= i2c_reg_addr;
      r_busy_q <= i2c_busy;
      host_ack <= (r_last_op == OP_HOST_WR) || (r_cap_op == OP_HOST_RD);
      if (r_cap_op == OP_HOST_RD) host_rdata <= rf_rdata;
      if (r_cap_op == OP_REFRESH) i2c_datai  <= rf_rdata;
      if (r_last_op == OP_REFRESH) begin
        r_ref_addr  <= rf_addr;
        r_ref_dirty <= w_stale_evt;
      end
      if (w_stale_evt)      r_stale <= 1'b1;
      else if (w_ref_clear) r_stale <= 1'b0;
      if (!r_stale)              r_timer <= '0;
      else if (r_timer < c_TMAX) r_timer <= r_timer + 1'b1;
    end
  end

  generate
    if (c_WP_EN) begin : g_wp
      logic r_wp_violation;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_wp_violation <= 1'b0;
        else if (w_wp_hit) r_wp_violation <= 1'b1;
      end
      assign wp_violation = r_wp_violation;
    end else begin : g_no_wp
      assign wp_violation = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_i2c_reg_arbiter                                                       |
// | Self-checking bench: memory-level model of register contents and shadow. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_reg_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RMAX = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i2c_we = 1'b0;
  logic [AW-1:0] i2c_reg_addr = '0;
  logic [DW-1:0] i2c_datao = '0;
  logic          i2c_busy = 1'b0;
  logic [DW-1:0] i2c_datai;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] rf_addr;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic          wp_violation;

  logic [DW-1:0] rf_mem [0:255];
  logic [DW-1:0] model  [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  i2c_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_MAX(RMAX), .WP_BASE(8'hF0)) dut (
    .clk(clk), .reset_n(reset_n),
    .i2c_we(i2c_we), .i2c_reg_addr(i2c_reg_addr), .i2c_datao(i2c_datao),
    .i2c_busy(i2c_busy), .i2c_datai(i2c_datai),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .wp_violation(wp_violation)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file behind the arbiter
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    rf_rdata <= rf_mem[rf_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Host transaction from a negedge; reads are checked against the model at ack
  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host_ack) begin got = 1; break; end
    end
    host_req = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL host_op_ack: addr %h no ack after 40 cycles, expected ack", a);
    end else if (we) begin
      model[a] = d;
    end else if (host_rdata !== model[a]) begin
      n_fail++;
      $display("FAIL host_read: addr %h got %h expected %h", a, host_rdata, model[a]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rf_we, rf_addr, rf_wdata, host_ack, host_rdata, i2c_datai, wp_violation} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h ack=%b rd=%h di=%h wp=%b expected all 0",
               rf_we, rf_addr, rf_wdata, host_ack, host_rdata, i2c_datai, wp_violation);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init();
    for (int a = 0; a < 'hA0; a++) host_op(1'b1, AW'(a), DW'($urandom));
  endtask

  task automatic test_idle_refresh();
    host_op(1'b1, 8'h10, 16'hBEEF);
    reset_n = 1'b0;
    i2c_reg_addr = 8'h10;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (i2c_datai !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL idle_refresh: i2c_datai got %h expected BEEF", i2c_datai);
    end
  endtask

  task automatic test_i2c_priority();
    bit got = 0;
    host_op(1'b1, 8'h30, 16'h5AA5);
    i2c_reg_addr = 8'h20; i2c_datao = 16'h1234; i2c_we = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    @(negedge clk);
    i2c_we = 1'b0;
    model[8'h20] = 16'h1234;
    n_tests++;
    if (!(rf_we === 1'b1 && rf_addr === 8'h20 && rf_wdata === 16'h1234)) begin
      n_fail++;
      $display("FAIL i2c_first: got we=%b addr=%h data=%h expected 1/20/1234", rf_we, rf_addr, rf_wdata);
    end
    @(negedge clk);
    n_tests++;
    if (!(rf_we === 1'b0 && rf_addr === 8'h30)) begin
      n_fail++;
      $display("FAIL host_next: got we=%b addr=%h expected 0/30", rf_we, rf_addr);
    end
    for (int i = 0; i < 10; i++) begin
      if (host_ack) begin got = 1; break; end
      @(negedge clk);
    end
    host_req = 1'b0;
    n_tests++;
    if (!got || host_rdata !== 16'h5AA5) begin
      n_fail++;
      $display("FAIL host_after_i2c: ack=%b rdata %h expected 1/5AA5", got, host_rdata);
    end
    host_op(1'b0, 8'h20, 16'h0);
  endtask

  task automatic test_host_write_shadow();
    i2c_reg_addr = 8'h10;
    repeat (6) @(negedge clk);
    host_op(1'b1, 8'h10, 16'hCAFE);
    repeat (6) @(negedge clk);
    n_tests++;
    if (i2c_datai !== 16'hCAFE) begin
      n_fail++;
      $display("FAIL host_write_shadow: i2c_datai got %h expected CAFE", i2c_datai);
    end
  endtask

  task automatic test_withdraw();
    bit bad = 0;
    i2c_datao = 16'h1111; i2c_we = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h31; host_wdata = 16'hDEAD;
    @(negedge clk);
    i2c_we = 1'b0; host_req = 1'b0;
    model[8'h10] = 16'h1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (host_ack || (rf_we && rf_addr == 8'h31)) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL withdraw: withdrawn host request got an access, expected none");
    end
    host_op(1'b0, 8'h31, 16'h0);
    host_op(1'b0, 8'h10, 16'h0);
  endtask

  // Back-to-back host traffic while the shadow address moves: forced refresh must get in
  task automatic test_back_to_back();
    bit done = 0, prev = 0, seen = 0;
    int acks = 0, dbl = 0, lat = 0;
    fork
      begin
        for (int k = 0; k < 12; k++)
          host_op(1'($urandom), AW'($urandom_range(8'h40, 8'h7F)), DW'($urandom));
        done = 1;
      end
      begin
        repeat (3) @(negedge clk);
        i2c_reg_addr = 8'h90;
        for (int i = 1; i <= RMAX + 3; i++) begin
          @(negedge clk);
          if (rf_addr == 8'h90 && !rf_we) begin seen = 1; lat = i; break; end
        end
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (host_ack) begin acks++; if (prev) dbl++; end
          prev = host_ack;
        end
      end
    join
    n_tests++;
    if (acks != 12 || dbl != 0) begin
      n_fail++;
      $display("FAIL back_to_back: acks %0d consecutive %0d expected 12/0", acks, dbl);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL forced_refresh: no refresh within %0d cycles, expected one", RMAX + 3);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (i2c_datai !== model[8'h90]) begin
      n_fail++;
      $display("FAIL forced_refresh_data: got %h expected %h (lat %0d)", i2c_datai, model[8'h90], lat);
    end
  endtask

  task automatic test_rerefresh();
    bit seen = 0;
    logic [DW-1:0] nd;
    i2c_reg_addr = 8'h88;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rf_addr == 8'h88 && !rf_we) begin seen = 1; break; end
    end
    @(negedge clk);
    nd = model[8'h88] ^ 16'h5A5A;
    i2c_datao = nd; i2c_we = 1'b1;
    @(negedge clk);
    i2c_we = 1'b0;
    model[8'h88] = nd;
    repeat (8) @(negedge clk);
    n_tests++;
    if (!seen || i2c_datai !== nd) begin
      n_fail++;
      $display("FAIL rerefresh: seen=%b i2c_datai %h expected %h", seen, i2c_datai, nd);
    end
  endtask

  task automatic test_reset_midop();
    bit bad = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    @(posedge clk);
    #1 reset_n = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host_ack) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_midop: host_ack seen after reset, expected none");
    end
  endtask

  task automatic test_wp();
    host_op(1'b1, 8'hF4, 16'h0BAD);
    i2c_reg_addr = 8'hF4; i2c_datao = 16'h7777; i2c_we = 1'b1;
    @(negedge clk);
    i2c_we = 1'b0;
`ifdef I2C_ARB_WP_EN
    n_tests++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wp_block: rf_we got %b expected 0", rf_we);
    end
    @(negedge clk);
    n_tests++;
    if (wp_violation !== 1'b1) begin
      n_fail++;
      $display("FAIL wp_flag: wp_violation got %b expected 1", wp_violation);
    end
`else
    model[8'hF4] = 16'h7777;
    n_tests++;
    if (rf_we !== 1'b1 || rf_addr !== 8'hF4) begin
      n_fail++;
      $display("FAIL wp_off_write: we=%b addr=%h expected 1/F4", rf_we, rf_addr);
    end
    @(negedge clk);
    n_tests++;
    if (wp_violation !== 1'b0) begin
      n_fail++;
      $display("FAIL wp_off_flag: wp_violation got %b expected 0", wp_violation);
    end
`endif
    host_op(1'b0, 8'hF4, 16'h0);
  endtask

  task automatic test_random();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
          host_op(1'($urandom), AW'($urandom_range(8'h40, 8'h7F)), DW'($urandom));
        end
      end
      begin
        for (int k = 0; k < 10; k++) begin
          logic [AW-1:0] a;
          a = AW'($urandom_range(8'h80, 8'h9F));
          i2c_reg_addr = a;
          i2c_busy = 1'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            i2c_datao = DW'($urandom); i2c_we = 1'b1;
            @(negedge clk);
            i2c_we = 1'b0;
            model[a] = i2c_datao;
          end
          repeat (RMAX + 8) @(negedge clk);
          n_tests++;
          if (i2c_datai !== model[a]) begin
            n_fail++;
            $display("FAIL random_shadow: addr %h got %h expected %h", a, i2c_datai, model[a]);
          end
          i2c_busy = 1'b0;
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_init();
    test_idle_refresh();
    test_i2c_priority();
    test_host_write_shadow();
    test_withdraw();
    test_back_to_back();
    test_rerefresh();
    test_reset_midop();
    test_wp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
